sincpde_chan_sched: RTL and testbench

// Multi-channel front-end for one sincpde_single_dfs estimator core.

---
 rtl/sincpde_chan_sched.sv | 195 +++++++++++++++++++
 tb/tb_sincpde_chan_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincpde_chan_sched.sv
// Multi-channel window scheduler in front of one sincpde_single_dfs core: queues
// windows, gates them on a peak threshold, runs them through the core one at a time.
//
// state | meaning
// IDLE  | waiting for a queued window; pops head and applies the peak gate
// ISSUE | one-cycle start pulse to the core with the held window
// WAIT  | core busy; timer runs until result or timeout
// EMIT  | result presented on out_* until accepted
module sincpde_chan_sched #(
    parameter int NCHAN   = 4,
    parameter int NTAPS   = 11,
    parameter int SW      = 18,
    parameter int RW      = 18,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         in_chan,
    input  logic [NTAPS*SW-1:0]   in_samples,
    input  logic [SW-1:0]         threshold,
    output logic                  core_sync_in,
    output logic [NTAPS*SW-1:0]   core_samples,
    input  logic                  core_sync_out,
    input  logic [RW-1:0]         core_p,
    input  logic [RW-1:0]         core_ampl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_chan,
    output logic [RW-1:0]         out_p,
    output logic [RW-1:0]         out_ampl,
    output logic [1:0]            out_flags
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

    state_t               state_q, state_d;
    logic [NTAPS*SW-1:0]  fifo_win_q  [DEPTH];
    logic [NTAPS*SW-1:0]  fifo_win_d  [DEPTH];
    logic [CW-1:0]        fifo_chan_q [DEPTH];
    logic [CW-1:0]        fifo_chan_d [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [NTAPS*SW-1:0]  win_q, win_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_chan_q, out_chan_d;
    logic [RW-1:0]        out_p_q, out_p_d;
    logic [RW-1:0]        out_ampl_q, out_ampl_d;
    logic [1:0]           out_flags_q, out_flags_d;

    logic                 push, pop;
    logic [NTAPS*SW-1:0]  head_win;
    logic [SW-1:0]        head_max;

    assign in_ready = (count_q != CNT_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head_win = fifo_win_q[rd_ptr_q];

    always_comb begin
        head_max = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (head_win[k*SW +: SW] > head_max) head_max = head_win[k*SW +: SW];
        end
    end

    always_comb begin
        fifo_win_d  = fifo_win_q;
        fifo_chan_d = fifo_chan_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        state_d     = state_q;
        win_d       = win_q;
        chan_d      = chan_q;
        timer_d     = timer_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        out_p_d     = out_p_q;
        out_ampl_d  = out_ampl_q;
        out_flags_d = out_flags_q;

        if (push) begin
            fifo_win_d[wr_ptr_q]  = in_samples;
            fifo_chan_d[wr_ptr_q] = in_chan;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    win_d  = head_win;
                    chan_d = fifo_chan_q[rd_ptr_q];
                    if (head_max >= threshold) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                        out_chan_d  = fifo_chan_q[rd_ptr_q];
                        out_p_d     = '0;
                        out_ampl_d  = '0;
                        out_flags_d = 2'b01;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (core_sync_out) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_chan_d  = chan_q;
                    out_p_d     = core_p;
                    out_ampl_d  = core_ampl;
                    out_flags_d = 2'b00;
                end else if (timer_q == T_LAST) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_chan_d  = chan_q;
                    out_p_d     = '0;
                    out_ampl_d  = '0;
                    out_flags_d = 2'b10;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        fifo_win_q  <= fifo_win_d;
        fifo_chan_q <= fifo_chan_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            win_q       <= '0;
            chan_q      <= '0;
            timer_q     <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_p_q     <= '0;
            out_ampl_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            win_q       <= win_d;
            chan_q      <= chan_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_p_q     <= out_p_d;
            out_ampl_q  <= out_ampl_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign core_sync_in = (state_q == S_ISSUE);
    assign core_samples = (state_q == S_ISSUE) ? win_q : '0;
    assign out_valid    = out_valid_q;
    assign out_chan     = out_chan_q;
    assign out_p        = out_p_q;
    assign out_ampl     = out_ampl_q;
    assign out_flags    = out_flags_q;

endmodule

// File: tb/tb_sincpde_chan_sched.sv
// Bench for sincpde_chan_sched: toy core stub (p = peak index + 2, ampl = peak + 5)
// with per-window latency, scoreboard of expected results in push order.
module tb_sincpde_chan_sched;

    localparam int NCHAN = 4, NTAPS = 11, SW = 18, RW = 18, DEPTH = 8, TIMEOUT = 16;
    localparam int CW = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [CW-1:0]        in_chan = '0;
    logic [NTAPS*SW-1:0]  in_samples = '0;
    logic [SW-1:0]        threshold = '0;
    logic                 core_sync_in;
    logic [NTAPS*SW-1:0]  core_samples;
    logic                 core_sync_out = 1'b0;
    logic [RW-1:0]        core_p = '0;
    logic [RW-1:0]        core_ampl = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [CW-1:0]        out_chan;
    logic [RW-1:0]        out_p;
    logic [RW-1:0]        out_ampl;
    logic [1:0]           out_flags;

    sincpde_chan_sched #(
        .NCHAN(NCHAN), .NTAPS(NTAPS), .SW(SW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_samples(in_samples),
        .threshold(threshold),
        .core_sync_in(core_sync_in), .core_samples(core_samples),
        .core_sync_out(core_sync_out), .core_p(core_p), .core_ampl(core_ampl),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_p(out_p), .out_ampl(out_ampl), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int p;
        int ampl;
        int flags;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sync_cnt = 0;
    int   sync_cyc = -1;
    int   spur_cyc = -1;
    int   push_cyc = 0;
    int   st_cnt = 0;
    bit   st_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void peak(input logic [NTAPS*SW-1:0] w, output int mx, output int am);
        mx = -1;
        am = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (int'(w[k*SW +: SW]) > mx) begin
                mx = int'(w[k*SW +: SW]);
                am = k;
            end
        end
    endfunction

    function automatic exp_t model(input int chan, input logic [NTAPS*SW-1:0] w,
                                   input int thr, input int lat);
        exp_t e;
        int   mx, am;
        peak(w, mx, am);
        e.chan = chan;
        if (mx < thr) begin
            e.p = 0; e.ampl = 0; e.flags = 1;
        end else if (lat >= 1 && lat <= TIMEOUT) begin
            e.p = am + 2; e.ampl = mx + 5; e.flags = 0;
        end else begin
            e.p = 0; e.ampl = 0; e.flags = 2;
        end
        return e;
    endfunction

    function automatic logic [NTAPS*SW-1:0] rand_win();
        logic [NTAPS*SW-1:0] w;
        int unsigned top;
        top = $urandom_range(300, 4000);
        for (int k = 0; k < NTAPS; k++) w[k*SW +: SW] = SW'($urandom_range(0, top));
        return w;
    endfunction

    // Core stub: answers lat cycles after the start pulse (lat 0 = never).
    always @(negedge clk) begin
        int lat, mx, am;
        core_sync_out = 1'b0;
        if (rst) begin
            st_armed = 1'b0;
        end else begin
            if (st_armed) begin
                st_cnt--;
                if (st_cnt == 0) begin
                    core_sync_out = 1'b1;
                    st_armed = 1'b0;
                end
            end
            if (cyc == spur_cyc) core_sync_out = 1'b1;
            if (core_sync_in) begin
                sync_cnt++;
                sync_cyc = cyc;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                peak(core_samples, mx, am);
                core_p    = RW'(am + 2);
                core_ampl = RW'(mx + 5);
                st_cnt    = lat;
                st_armed  = (lat > 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic note(input int chan, input logic [NTAPS*SW-1:0] w, input int lat);
        exp_t e;
        e = model(chan, w, int'(threshold), lat);
        exp_q.push_back(e);
        if (e.flags != 1) lat_q.push_back(lat);
    endtask

    task automatic send(input int chan, input logic [NTAPS*SW-1:0] w, input int lat);
        in_valid   = 1'b1;
        in_chan    = CW'(chan);
        in_samples = w;
        chk("send_ready", int'(in_ready), 1);
        push_cyc = cyc;
        note(chan, w, lat);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.chan = -1; e.p = -1; e.ampl = -1; e.flags = -1;
        end
        chk({tag, "_chan"},  int'(out_chan),  e.chan);
        chk({tag, "_p"},     int'(out_p),     e.p);
        chk({tag, "_ampl"},  int'(out_ampl),  e.ampl);
        chk({tag, "_flags"}, int'(out_flags), e.flags);
    endtask

    task automatic take(input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, int'(out_valid), 1);
        check_out(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, int'(out_valid), 0);
    endtask

    task automatic wait_sync(input int s0);
        int n = 0;
        while (sync_cnt == s0 && n < 100) begin
            tick();
            n++;
        end
        chk("sync_seen", int'(sync_cnt != s0), 1);
    endtask

    task automatic traffic(input int n_new, input int budget);
        logic [NTAPS*SW-1:0] w;
        int ch, lat, sent, n;
        sent = 0;
        n = 0;
        ch = 0;
        lat = 0;
        w = '0;
        while ((sent < n_new || exp_q.size() > 0) && n < budget) begin
            in_valid = (sent < n_new) && ($urandom_range(0, 99) < 60);
            if (in_valid) begin
                ch  = int'($urandom_range(0, NCHAN - 1));
                w   = rand_win();
                lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                                  : int'($urandom_range(1, 6));
                in_chan    = CW'(ch);
                in_samples = w;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                note(ch, w, lat);
                sent++;
            end
            if (out_valid && out_ready) check_out("rnd");
            tick();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("traffic_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NTAPS*SW-1:0] wv, w;
        int ref_win [NTAPS] = '{23, 23, 22, 169, 1697, 2833, 1640, 465, 81, 5, 1};
        int s0, n, first, pushes;

        for (int k = 0; k < NTAPS; k++) wv[k*SW +: SW] = SW'(ref_win[k]);

        // reset values
        repeat (3) tick();
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_chan",  int'(out_chan), 0);
        chk("rst_out_p",     int'(out_p), 0);
        chk("rst_out_ampl",  int'(out_ampl), 0);
        chk("rst_out_flags", int'(out_flags), 0);
        chk("rst_sync_in",   int'(core_sync_in), 0);
        chk("rst_samples",   int'(core_samples == '0), 1);
        rst = 1'b0;
        tick();

        // reference window through the core
        threshold = SW'(1000);
        s0 = sync_cnt;
        send(2, wv, 3);
        wait_sync(s0);
        chk("issue_latency", sync_cyc - push_cyc, 2);
        take("ref");
        chk("ref_p_abs", int'(out_p), 7);
        chk("ref_ampl_abs", int'(out_ampl), 2838);

        // same window below threshold: skipped, no core start
        threshold = SW'(3000);
        s0 = sync_cnt;
        send(2, wv, 3);
        chk("skip_early", int'(out_valid), 0);
        tick();
        chk("skip_at_2", int'(out_valid), 1);
        take("skip");
        chk("skip_nosync", sync_cnt, s0);

        // core never answers
        threshold = SW'(1000);
        s0 = sync_cnt;
        send(3, wv, 0);
        wait_sync(s0);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        first = cyc;
        chk("to_latency", first - sync_cyc, TIMEOUT + 1);
        take("to");
        spur_cyc = cyc + 2;
        repeat (6) begin
            tick();
            chk("to_no_extra", int'(out_valid), 0);
        end

        // answer on the timeout cycle wins; one cycle later is ignored
        send(0, wv, TIMEOUT);
        take("exact");
        send(1, wv, TIMEOUT + 1);
        take("late");
        repeat (3) begin
            tick();
            chk("late_no_extra", int'(out_valid), 0);
        end

        // backpressure: DEPTH queued plus one held
        threshold = SW'(1000);
        out_ready = 1'b0;
        pushes = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            w = rand_win();
            in_valid   = 1'b1;
            in_chan    = CW'(i % NCHAN);
            in_samples = w;
            if (!in_ready) break;
            note(i % NCHAN, w, int'($urandom_range(1, 5)));
            pushes++;
            tick();
        end
        chk("bp_pushes", pushes, DEPTH + 1);
        repeat (3) begin
            tick();
            chk("bp_stall", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        traffic(0, 2000);

        // randomized traffic
        threshold = SW'(2000);
        traffic(40, 4000);

        // reset while waiting on the core, then a stale answer
        threshold = SW'(0);
        s0 = sync_cnt;
        send(1, rand_win(), 0);
        wait_sync(s0);
        send(2, rand_win(), 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        spur_cyc = cyc + 1;
        s0 = sync_cnt;
        repeat (8) begin
            chk("rw_out_valid", int'(out_valid), 0);
            chk("rw_in_ready", int'(in_ready), 1);
            tick();
        end
        chk("rw_no_issue", sync_cnt, s0);
        chk("rw_flags", int'(out_flags), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
